// File: rtl/serial_cmd_rx.sv
// Host serial command receiver: 40-bit frames (R/W, 7-bit address, 32-bit data) into master_clk writes.
// Define SERIAL_READBACK_EN to build the read path (readback_addr / serial_sdo).
module serial_cmd_rx (
  input  logic        master_clk,
  input  logic        reset_n,
  input  logic        serial_sclk,
  input  logic        serial_sen_n,
  input  logic        serial_sdi,
  output logic        serial_sdo,
  output logic [6:0]  serial_addr,
  output logic [31:0] serial_data,
  output logic        serial_strobe,
  output logic [6:0]  readback_addr,
  input  logic [31:0] readback_data,
  output logic [7:0]  frame_err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ACCEPT = 2'd2,
    ABORT  = 2'd3
  } state_t;

  state_t      state, state_nxt;

  logic [2:0]  sclk_sr;
  logic [2:0]  sen_sr;
  logic [2:0]  sdi_sr;
  logic [1:0]  sync_vld;
  logic        sen_armed;

  logic        sclk_rise;
  logic        sen_fall;
  logic        sen_rise;

  logic [5:0]  bit_cnt, cnt_nxt;
  logic [39:0] shift_sr, sr_nxt;
  logic        shift_en;
  logic        rd_frame_ok;
  logic        rd_ok_q;

  always_ff @(posedge master_clk) begin
    if (!reset_n) begin
      sclk_sr  <= '0;
      sen_sr   <= '1;
      sdi_sr   <= '0;
      sync_vld <= '0;
    end else begin
      sclk_sr  <= {sclk_sr[1:0], serial_sclk};
      sen_sr   <= {sen_sr[1:0], serial_sen_n};
      sdi_sr   <= {sdi_sr[1:0], serial_sdi};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // The synchronizer resets to sen_n high, so a host still holding sen_n low
  // after reset would look like a new falling edge; require a real high first.
  always_ff @(posedge master_clk) begin
    if (!reset_n) begin
      sen_armed <= 1'b0;
    end else if (sync_vld[1] && sen_sr[1]) begin
      sen_armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sen_fall  = sen_sr[2] & ~sen_sr[1];
  assign sen_rise  = sen_sr[1] & ~sen_sr[2];

  // A coincident sclk edge is shifted in before the frame length is judged.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cnt_nxt   = bit_cnt;
    sr_nxt    = shift_sr;
    case (state)
      IDLE: begin
        if (sen_fall && sen_armed) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_nxt  = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
          sr_nxt   = {shift_sr[38:0], sdi_sr[2]};
        end
        if (sen_rise) begin
          state_nxt = ((cnt_nxt == 6'd40) && !sr_nxt[39]) ? ACCEPT : ABORT;
        end
      end
      ACCEPT:  state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge master_clk) begin
    if (!reset_n) begin
      bit_cnt       <= '0;
      shift_sr      <= '0;
      rd_ok_q       <= 1'b0;
      serial_addr   <= '0;
      serial_data   <= '0;
      serial_strobe <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      serial_strobe <= 1'b0;
      if (state == IDLE && state_nxt == SHIFT) begin
        bit_cnt  <= '0;
        shift_sr <= '0;
      end else begin
        bit_cnt  <= cnt_nxt;
        shift_sr <= sr_nxt;
      end
      if (state == SHIFT && sen_rise) begin
        rd_ok_q <= rd_frame_ok;
      end
      if (state == ACCEPT) begin
        serial_addr   <= shift_sr[38:32];
        serial_data   <= shift_sr[31:0];
        serial_strobe <= 1'b1;
      end
      if (state == ABORT && !rd_ok_q && frame_err_cnt != 8'hFF) begin
        frame_err_cnt <= frame_err_cnt + 8'd1;
      end
    end
  end

`ifdef SERIAL_READBACK_EN
  logic        sclk_fall;
  logic        rb_trig;
  logic [1:0]  rb_pipe;
  logic [31:0] rb_shift;
  logic        rb_active;

  assign sclk_fall   = ~sclk_sr[1] & sclk_sr[2];
  assign rd_frame_ok = (cnt_nxt == 6'd40) && sr_nxt[39];
  assign rb_trig     = shift_en && (cnt_nxt == 6'd8) && sr_nxt[7];

  // Address goes out on the 8th bit; the external word is sampled two cycles later.
  always_ff @(posedge master_clk) begin
    if (!reset_n) begin
      readback_addr <= '0;
      rb_pipe       <= '0;
      rb_shift      <= '0;
      rb_active     <= 1'b0;
    end else if (state != SHIFT) begin
      rb_pipe   <= '0;
      rb_shift  <= '0;
      rb_active <= 1'b0;
    end else begin
      rb_pipe <= {rb_pipe[0], rb_trig};
      if (rb_trig) begin
        readback_addr <= sr_nxt[6:0];
      end
      if (rb_pipe[1]) begin
        rb_shift  <= readback_data;
        rb_active <= 1'b1;
      end else if (sclk_fall && bit_cnt >= 6'd8) begin
        rb_shift <= {rb_shift[30:0], 1'b0};
      end
    end
  end

  assign serial_sdo = rb_active & rb_shift[31];
`else
  logic unused_rb;

  assign rd_frame_ok   = 1'b0;
  assign readback_addr = '0;
  assign serial_sdo    = 1'b0;
  assign unused_rb     = ^{readback_data, shift_en};
`endif

endmodule

// File: doc/serial_cmd_rx.md
SERIAL_CMD_RX -- requirements
Module: serial_cmd_rx

Interface
REQ-001 SHALL have port master_clk  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port serial_sclk  input  1  host serial clock, asynchronous to master_clk, at most master_clk/8.
REQ-004 SHALL have port serial_sen_n  input  1  frame enable, active-low, asynchronous.
REQ-005 SHALL have port serial_sdi  input  1  host data in, MSB first.
REQ-006 SHALL have port serial_sdo  output  1  readback data out (Configuration).
REQ-007 SHALL have port serial_addr  output  7  register address of last accepted write.
REQ-008 SHALL have port serial_data  output  32  data of last accepted write.
REQ-009 SHALL have port serial_strobe  output  1  one-cycle write pulse.
REQ-010 SHALL have port readback_addr  output  7  address of current read frame.
REQ-011 SHALL have port readback_data  input  32  word selected externally by readback_addr.
REQ-012 SHALL have port frame_err_cnt  output  8  count of malformed frames.

Function
REQ-013 SHALL pass serial_sclk, serial_sen_n, serial_sdi each through a 2-flop synchronizer, then a third flop for edge detection.
REQ-014 SHALL implement states IDLE, SHIFT, ACCEPT, ABORT.
REQ-015 SHALL move IDLE->SHIFT on synchronized falling edge of serial_sen_n, clearing the 6-bit bit counter and the 40-bit shift register.
REQ-016 SHALL, in SHIFT, shift synchronized serial_sdi into the shift register LSB on each synchronized sclk rising edge and increment the bit counter, saturating at 63.
REQ-017 SHALL define the frame as bit 39 = R/W (1 = read), bits 38:32 = address, bits 31:0 = data.
REQ-018 SHALL, on synchronized rising edge of serial_sen_n in SHIFT, go to ACCEPT if the count equals 40 and R/W = 0; otherwise go to ABORT.
REQ-019 SHALL, in ACCEPT, load serial_addr and serial_data, assert serial_strobe for exactly one cycle with them valid, and return to IDLE next cycle.
REQ-020 SHALL hold serial_addr and serial_data stable between accepted writes.
REQ-021 SHALL, in ABORT, increment frame_err_cnt (saturating at 255) unless the frame was a read with count = 40, and return to IDLE next cycle with no strobe.
REQ-022 SHALL treat an sclk edge and a sen rising edge detected in the same cycle as shift first, then evaluate the count.
REQ-023 SHALL ignore sclk edges and serial_sdi in IDLE, ACCEPT, and ABORT.
REQ-024 SHALL set latency from the synchronized sen_n rising edge to serial_strobe high at exactly 2 master_clk cycles.

Reset
REQ-025 SHALL, while reset_n = 0 at a clock edge, set state to IDLE, serial_addr = 0, serial_data = 0, serial_strobe = 0, readback_addr = 0, frame_err_cnt = 0, serial_sdo = 0, and synchronizer flops to idle levels (sen_n = 1, sclk = 0).
REQ-026 SHALL, on reset asserted mid-frame, discard the frame; after release it SHALL wait for a fresh sen_n falling edge.

Configuration
REQ-027 SHALL compile readback logic only when macro SERIAL_READBACK_EN is defined.
REQ-028 SHALL, with SERIAL_READBACK_EN, when the count reaches 8 with bit 7 = 1, drive readback_addr from bits 6:0 and, 2 cycles later, load readback_data into a 32-bit output shifter.
REQ-029 SHALL, with SERIAL_READBACK_EN, present shifter MSB on serial_sdo and shift left on each synchronized sclk falling edge while in SHIFT with count >= 8.
REQ-030 SHALL, with SERIAL_READBACK_EN, drive serial_sdo to 0 outside read frames.
REQ-031 SHALL, without SERIAL_READBACK_EN, tie serial_sdo and readback_addr to 0 and treat read frames as malformed (counted by REQ-021).

Verification
REQ-032 SHALL cover: write frame R/W = 0, addr = 7'h05, data = 32'hDEADBEEF -> single serial_strobe pulse with serial_addr = 5, serial_data = DEADBEEF, 2 cycles after sen_n rise.
REQ-033 SHALL cover: 39-bit frame, then 41-bit frame -> no strobe, frame_err_cnt = 2, outputs keep prior values.
REQ-034 SHALL cover: with macro, read frame addr = 7'h22, readback_data = 32'h12345678 -> readback_addr = 22, sdo bits 12345678 MSB first on bits 8..39.
REQ-035 SHALL cover: reset_n low at bit 20 of a write, then a full write addr = 1, data = 1 -> only the second frame strobes.
REQ-036 SHALL cover: 300 malformed frames -> frame_err_cnt saturates at 255.
REQ-037 SHALL cover: without macro, a read frame -> serial_sdo = 0 throughout, frame_err_cnt increments by 1.
